pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 123 ++++++++++++
 tb/tb_pwm_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with an input synchronizer, a two-state
// measurement FSM and a valid/ready result register with overrun reporting.
module pwm_capture #(
  parameter  int MAX_COUNTER_VALUE = 255,
  parameter  int SYNC_STAGES       = 2,
  localparam int COUNTER_BITS      = $clog2(MAX_COUNTER_VALUE + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    signal_in,
  input  logic                    capture_ready,
  output logic [COUNTER_BITS-1:0] period_value,
  output logic [COUNTER_BITS-1:0] high_value,
  output logic                    capture_valid,
  output logic                    timeout,
  output logic                    overrun
);

  localparam logic [COUNTER_BITS-1:0] COUNT_MAX = COUNTER_BITS'(MAX_COUNTER_VALUE);
  localparam logic [COUNTER_BITS-1:0] COUNT_ONE = COUNTER_BITS'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    prev_reg;
  logic                    sync_level;
  logic                    rise;
  logic                    fall;
  state_t                  state_reg;
  logic [COUNTER_BITS-1:0] counter_reg;
  logic [COUNTER_BITS-1:0] high_count_reg;
  logic                    res_valid_reg;
  logic [COUNTER_BITS-1:0] res_period_reg;
  logic [COUNTER_BITS-1:0] res_high_reg;

  // Synchronizer keeps running regardless of enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], signal_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_level = sync_reg[SYNC_STAGES-1];
  assign rise       = sync_level & ~prev_reg;
  assign fall       = ~sync_level & prev_reg;

  // Measurement FSM; a result is a one-cycle strobe into the output stage.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      high_count_reg <= '0;
      res_valid_reg  <= 1'b0;
      res_period_reg <= '0;
      res_high_reg   <= '0;
      timeout        <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      timeout       <= 1'b0;
      if (!enable) begin
        state_reg      <= IDLE;
        counter_reg    <= '0;
        high_count_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rise) begin
              state_reg   <= MEASURE;
              counter_reg <= COUNT_ONE;
            end
          end
          MEASURE: begin
            if (rise) begin
              res_valid_reg  <= 1'b1;
              res_period_reg <= counter_reg;
              res_high_reg   <= high_count_reg;
              counter_reg    <= COUNT_ONE;
            end else if (counter_reg == COUNT_MAX) begin
              // Saturated without a closing rise: give up rather than wrap.
              timeout        <= 1'b1;
              state_reg      <= IDLE;
              counter_reg    <= '0;
              high_count_reg <= '0;
            end else begin
              counter_reg <= counter_reg + COUNT_ONE;
              if (fall) high_count_reg <= counter_reg;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Result register: a held, unaccepted result wins over a newer one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      period_value  <= '0;
      high_value    <= '0;
      capture_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (res_valid_reg) begin
        if (!capture_valid || capture_ready) begin
          period_value  <= res_period_reg;
          high_value    <= res_high_reg;
          capture_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (capture_valid && capture_ready) begin
        capture_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized PWM stimulus checked against an edge-time reference model,
// plus directed overrun, handshake, enable and reset scenarios.
module tb_pwm_capture;

  localparam int MAXV = 255;
  localparam int NS   = 2;
  localparam int CB   = 8;
  localparam int LAT  = NS + 2;   // signal_in transition to capture_valid

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          signal_in = 1'b0;
  logic          capture_ready = 1'b0;
  logic [CB-1:0] period_value;
  logic [CB-1:0] high_value;
  logic          capture_valid;
  logic          timeout;
  logic          overrun;

  pwm_capture #(.MAX_COUNTER_VALUE(MAXV), .SYNC_STAGES(NS)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .signal_in(signal_in),
    .capture_ready(capture_ready), .period_value(period_value),
    .high_value(high_value), .capture_valid(capture_valid),
    .timeout(timeout), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit sb_on    = 1'b0;
  int n_cap = 0, n_to = 0, n_ov = 0;
  int last_p = 0, last_h = 0;

  // Reference model: results follow from the cycle numbers of driven edges.
  bit m_armed = 1'b0;
  int m_last_rise = 0, m_last_fall = 0;
  int exp_p[$], exp_h[$], exp_c[$], exp_to[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    if (capture_valid && capture_ready) begin
      n_cap++;
      last_p = int'(period_value);
      last_h = int'(high_value);
      $display("cycle %0d: capture period=%0d high=%0d", cyc, last_p, last_h);
      if (sb_on) begin
        if (exp_p.size() == 0) check("extra_result", 1, 0);
        else begin
          check("period", last_p, exp_p.pop_front());
          check("high", last_h, exp_h.pop_front());
          check("arrival", cyc, exp_c.pop_front());
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (timeout) begin
      n_to++;
      $display("cycle %0d: timeout", cyc);
      if (sb_on) begin
        if (exp_to.size() == 0) check("extra_timeout", 1, 0);
        else check("timeout_cyc", cyc, exp_to.pop_front());
      end
    end
    if (overrun) begin
      n_ov++;
      $display("cycle %0d: overrun", cyc);
    end
  endtask

  task automatic model_rise(input int t);
    if (m_armed) begin
      if (t - m_last_rise <= MAXV) begin
        exp_p.push_back(t - m_last_rise);
        exp_h.push_back(m_last_fall - m_last_rise);
        exp_c.push_back(t + LAT);
      end else begin
        exp_to.push_back(m_last_rise + NS + 1 + MAXV);
      end
    end
    m_armed = 1'b1;
    m_last_rise = t;
  endtask

  task automatic drive_rise();
    signal_in = 1'b1;
    if (sb_on) model_rise(cyc);
  endtask

  task automatic drive_fall();
    signal_in = 1'b0;
    m_last_fall = cyc;
  endtask

  task automatic pwm(input int h, input int l, input int n);
    repeat (n) begin
      drive_rise();
      repeat (h) step();
      drive_fall();
      repeat (l) step();
    end
  endtask

  // Hold the input low; an armed measurement must time out within n cycles.
  task automatic quiet(input int n);
    signal_in = 1'b0;
    if (sb_on && m_armed && (cyc + n >= m_last_rise + NS + 1 + MAXV)) begin
      exp_to.push_back(m_last_rise + NS + 1 + MAXV);
      m_armed = 1'b0;
    end
    repeat (n) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"}, int'(period_value), 0);
    check({tag, "_high"}, int'(high_value), 0);
    check({tag, "_valid"}, int'(capture_valid), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int t3;
    // Reset state
    signal_in = 1'b1;
    repeat (3) step();
    check_zero_outputs("reset");
    signal_in = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    enable = 1'b1;
    capture_ready = 1'b1;
    repeat (4) step();

    // Scoreboarded traffic: steady, boundary period, random bursts
    sb_on = 1'b1;
    pwm(3, 7, 6);
    quiet(300);
    pwm(100, 155, 2);
    quiet(300);
    for (int b = 0; b < 6; b++) begin
      int np;
      np = int'($urandom_range(2, 5));
      for (int k = 0; k < np; k++)
        pwm(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1);
      if (b % 2 == 1) quiet(300);
    end
    quiet(300);
    check("sb_results_left", exp_p.size(), 0);
    check("sb_timeouts_left", exp_to.size(), 0);
    check("sb_overruns", n_ov, 0);

    // Overrun: held result (4,2) survives a dropped (6,3)
    sb_on = 1'b0;
    capture_ready = 1'b0;
    n_cap = 0;
    n_ov = 0;
    pwm(2, 2, 1);
    pwm(3, 3, 1);
    drive_rise();
    repeat (2) step();
    drive_fall();
    repeat (10) step();
    check("ovr_valid", int'(capture_valid), 1);
    check("ovr_period", int'(period_value), 4);
    check("ovr_high", int'(high_value), 2);
    check("ovr_pulses", n_ov, 1);
    check("ovr_no_accept", n_cap, 0);
    capture_ready = 1'b1;
    step();
    check("ovr_accept_cnt", n_cap, 1);
    check("ovr_accept_p", last_p, 4);
    check("ovr_accept_h", last_h, 2);
    check("ovr_valid_clear", int'(capture_valid), 0);
    enable = 1'b0;
    repeat (4) step();

    // New result arriving in the handshake cycle
    enable = 1'b1;
    capture_ready = 1'b0;
    n_cap = 0;
    n_ov = 0;
    pwm(2, 2, 1);
    pwm(3, 3, 1);
    drive_rise();
    t3 = cyc;
    repeat (3) step();
    check("hs_pre_valid", int'(capture_valid), 1);
    check("hs_pre_period", int'(period_value), 4);
    capture_ready = 1'b1;
    step();
    check("hs_cycle", cyc, t3 + LAT);
    check("hs_valid", int'(capture_valid), 1);
    check("hs_period", int'(period_value), 6);
    check("hs_high", int'(high_value), 3);
    check("hs_accepted_p", last_p, 4);
    check("hs_overrun", n_ov, 0);
    drive_fall();
    step();
    check("hs_second_p", last_p, 6);
    check("hs_valid_clear", int'(capture_valid), 0);
    enable = 1'b0;
    repeat (4) step();

    // Enable drop mid-period, then reset mid-period with input high
    exp_p.delete(); exp_h.delete(); exp_c.delete(); exp_to.delete();
    m_armed = 1'b0;
    sb_on = 1'b1;
    n_ov = 0;
    enable = 1'b1;
    pwm(5, 5, 1);
    drive_rise();
    repeat (3) step();
    enable = 1'b0;
    m_armed = 1'b0;
    repeat (3) step();
    signal_in = 1'b0;
    repeat (4) step();
    signal_in = 1'b1;
    repeat (4) step();
    signal_in = 1'b0;
    repeat (8) step();
    enable = 1'b1;
    pwm(4, 6, 3);
    drive_rise();
    repeat (8) step();
    reset_n = 1'b0;
    m_armed = 1'b0;
    exp_p.delete(); exp_h.delete(); exp_c.delete();
    repeat (3) step();
    check_zero_outputs("midrst");
    reset_n = 1'b1;
    model_rise(cyc);
    repeat (3) step();
    drive_fall();
    repeat (5) step();
    pwm(3, 5, 2);
    quiet(300);
    check("en_results_left", exp_p.size(), 0);
    check("en_timeouts_left", exp_to.size(), 0);
    check("en_overruns", n_ov, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
